up_down_counter4: RTL and testbench

- Synchronous 4-bit binary up/down counter with count enable and asynchronous active-low reset.
- Used as a general-purpose event/position counter.
- Wraps modulo 16 in both directions.
- Registered output; no handshake.

---
 rtl/up_down_counter4.sv | 36 +++
 tb/tb_up_down_counter4.sv | 104 ++++++++++
 2 files changed

// File: rtl/up_down_counter4.sv
// Modulo-2^WIDTH up/down counter with count enable and asynchronous active-low reset.
// The count output comes straight from the state register, so no input reaches it combinationally.
module up_down_counter4 #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] count,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             u_d
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (en) begin
            // Plain WIDTH-bit add/subtract wraps silently in both directions.
            count_d = u_d ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_up_down_counter4.sv
// Directed bench for up_down_counter4: reset, up/down counting, wrap in both directions,
// asynchronous mid-cycle reset and enable hold. Clock rises at t = 10 + 20k ns.
`timescale 1ns/1ps
module tb_up_down_counter4;

    logic [3:0] count;
    logic       clk;
    logic       reset;
    logic       en;
    logic       u_d;

    int tests_run = 0;
    int tests_failed = 0;

    up_down_counter4 #(.WIDTH(4)) dut (
        .count (count),
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .u_d   (u_d)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        u_d   = 1'b1;

        // Scenario 1: reset held through edge 10, released at 18.
        #11 check("reset_edge10", count, 4'd0);           // t=11
        #7  reset = 1'b1;                                  // t=18
        #7  check("release_no_change", count, 4'd0);      // t=25
        #3  en = 1'b1;                                     // t=28

        // Scenario 2: up count 1..13 after edges 30..270.
        #3;                                                // t=31
        for (int k = 1; k <= 13; k++) begin
            check("up_count", count, 4'(k));
            if (k < 13) #20;
        end                                                // t=271

        // Scenario 3: down count.
        #7  u_d = 1'b0;                                    // t=278
        #13 check("down_290", count, 4'd12);               // t=291
        #20 check("down_310", count, 4'd11);               // t=311
        #20 check("down_330", count, 4'd10);               // t=331

        // Scenario 4: async reset between edges, release with u_d=0.
        #5  reset = 1'b0;                                  // t=336
        #1  check("async_reset_337", count, 4'd0);         // t=337
        #12 reset = 1'b1;                                  // t=349
        #2  check("down_wrap_350", count, 4'd15);          // t=351
        #20 check("down_370", count, 4'd14);               // t=371
        #20 check("down_390", count, 4'd13);               // t=391

        // Scenario 5: second reset, held across an enabled edge.
        #18 reset = 1'b0;                                  // t=409
        #1  check("async_reset_410", count, 4'd0);         // t=410
        #1  check("reset_over_edge410", count, 4'd0);      // t=411
        #18 reset = 1'b1;                                  // t=429
        #2  check("down_wrap_430", count, 4'd15);          // t=431

        // 20-edge up run from 0 covering the 15 -> 0 wrap.
        #8  reset = 1'b0;                                  // t=439
        #1  check("reset_439", count, 4'd0);               // t=440
        #5  begin reset = 1'b1; u_d = 1'b1; end            // t=445
        #6;                                                // t=451
        for (int k = 1; k <= 20; k++) begin
            check("up_wrap_run", count, 4'(k & 15));
            if (k < 20) #20;
        end                                                // t=831 count=4
        #20 check("up_to_5", count, 4'd5);                 // t=851
        #20 check("up_to_6", count, 4'd6);                 // t=871
        #20 check("up_to_7", count, 4'd7);                 // t=891

        // Scenario 6: hold at 7 for three edges while u_d toggles.
        #4  begin en = 1'b0; u_d = 1'b0; end               // t=895
        #1  check("no_comb_path", count, 4'd7);            // t=896
        #15 check("hold_910", count, 4'd7);                // t=911
        #4  u_d = 1'b1;                                    // t=915
        #16 check("hold_930", count, 4'd7);                // t=931
        #4  u_d = 1'b0;                                    // t=935
        #16 check("hold_950", count, 4'd7);                // t=951
        #4  en = 1'b1;                                     // t=955
        #16 check("resume_down_970", count, 4'd6);         // t=971
        #20 check("resume_down_990", count, 4'd5);         // t=991

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
